// File: rtl/bus_referee_rr.sv
// Round-robin referee sharing one req/ack responder among NUM_REQ requesters, with a timeout watchdog.
// Grant one edge after a sampled request; ack pulses one edge after winner_ack or timeout; requesters wait on req, never dropped.
module bus_referee_rr #(
    parameter int NUM_REQ        = 4,
    parameter int REQ_DATA_WIDTH = 8,
    parameter int ACK_DATA_WIDTH = 8,
    parameter int TIMEOUT        = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0] data_req,
    output logic [NUM_REQ-1:0]                ack,
    output logic [ACK_DATA_WIDTH-1:0]         data_ack,
    output logic                              err,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              winner_req,
    output logic [REQ_DATA_WIDTH-1:0]         winner_data_req,
    input  logic                              winner_ack,
    input  logic [ACK_DATA_WIDTH-1:0]         winner_data_ack
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic [IW-1:0]             gid_q, gid_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      wreq_q, wreq_d;
    logic [REQ_DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [NUM_REQ-1:0]        ack_q, ack_d;
    logic [ACK_DATA_WIDTH-1:0] dack_q, dack_d;
    logic                      err_q, err_d;
    logic [IW-1:0]             pick;
    logic [IW:0]               idx;
    logic                      tmo;

    // Scan offsets high to low so the smallest offset from ptr wins last.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(NUM_REQ)) begin
                idx = idx - (IW+1)'(NUM_REQ);
            end
            if (req[idx[IW-1:0]]) begin
                pick = idx[IW-1:0];
            end
        end
    end

    assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        wreq_d  = wreq_q;
        wdat_d  = wdat_q;
        ack_d   = '0;
        dack_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    gid_d   = pick;
                    wdat_d  = data_req[int'(pick)*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
                    wreq_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real acknowledge beats a watchdog expiry on the same edge.
                if (winner_ack) begin
                    wreq_d       = 1'b0;
                    ack_d[gid_q] = 1'b1;
                    dack_d       = winner_data_ack;
                    state_d      = ST_DONE;
                end else if (tmo) begin
                    wreq_d       = 1'b0;
                    ack_d[gid_q] = 1'b1;
                    err_d        = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                ptr_d   = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            wreq_q  <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= '0;
            dack_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            wreq_q  <= wreq_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            dack_q  <= dack_d;
            err_q   <= err_d;
        end
    end

    assign ack             = ack_q;
    assign data_ack        = dack_q;
    assign err             = err_q;
    assign grant_id        = gid_q;
    assign busy            = (state_q != ST_IDLE);
    assign winner_req      = wreq_q;
    assign winner_data_req = wdat_q;
endmodule

// File: tb/tb_bus_referee_rr.sv
// Scenario bench for bus_referee_rr with a scoreboard of expected ack pulses.
module tb_bus_referee_rr;
    localparam int N  = 4;
    localparam int RW = 8;
    localparam int AW = 8;
    localparam int TO = 16;

    typedef struct {
        logic [N-1:0]  ack;
        logic [AW-1:0] dat;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*RW-1:0] data_req;
    logic [N-1:0]  ack;
    logic [AW-1:0] data_ack;
    logic          err;
    logic [1:0]    grant_id;
    logic          busy;
    logic          winner_req;
    logic [RW-1:0] winner_data_req;
    logic          winner_ack;
    logic [AW-1:0] winner_data_ack;

    logic          resp_auto;
    logic          man_ack;
    logic [AW-1:0] man_dat;
    logic          auto_ack;
    logic [AW-1:0] auto_dat;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    bus_referee_rr #(.NUM_REQ(N), .REQ_DATA_WIDTH(RW), .ACK_DATA_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .data_req(data_req),
        .ack(ack), .data_ack(data_ack), .err(err), .grant_id(grant_id), .busy(busy),
        .winner_req(winner_req), .winner_data_req(winner_data_req),
        .winner_ack(winner_ack), .winner_data_ack(winner_data_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Registered responder: answers one cycle after seeing winner_req, returns data+1.
    always @(posedge clk) begin
        if (rst) begin
            auto_ack <= 1'b0;
            auto_dat <= '0;
        end else begin
            auto_ack <= winner_req && !auto_ack;
            auto_dat <= winner_data_req + 8'd1;
        end
    end
    assign winner_ack      = resp_auto ? auto_ack : man_ack;
    assign winner_data_ack = resp_auto ? auto_dat : man_dat;

    always @(negedge clk) begin
        exp_t e;
        if (ack !== '0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_ack ack=%b required none", ack);
            end else begin
                e = sb.pop_front();
                if (ack !== e.ack || data_ack !== e.dat || err !== e.err) begin
                    bad++;
                    $display("FAIL sb_ack got ack=%b dat=%h err=%b required ack=%b dat=%h err=%b",
                             ack, data_ack, err, e.ack, e.dat, e.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [AW-1:0] d, input logic e);
        exp_t x;
        x.ack = a;
        x.dat = d;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_grant(output int t);
        t = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (winner_req === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            total++;
            bad++;
            $display("FAIL grant_wait winner_req=%b required 1 within 20 cycles", winner_req);
        end
    endtask

    task automatic wait_low();
        for (int k = 0; k < 40; k++) begin
            if (winner_req === 1'b0) return;
            step();
        end
        total++;
        bad++;
        $display("FAIL low_wait winner_req=%b required 0 within 40 cycles", winner_req);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (busy === 1'b0 && winner_req === 1'b0) return;
            step();
        end
        total++;
        bad++;
        $display("FAIL idle_wait busy=%b required 0 within 40 cycles", busy);
    endtask

    task automatic check_gid(input string nm, input logic [1:0] exp_id);
        total++;
        if (grant_id !== exp_id) begin
            bad++;
            $display("FAIL %s grant_id=%0d required %0d", nm, grant_id, exp_id);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({ack, data_ack, err, grant_id, busy, winner_req, winner_data_req} !== '0) begin
            bad++;
            $display("FAIL reset_outputs ack=%b dack=%h err=%b gid=%0d busy=%b wreq=%b wdat=%h required all 0",
                     ack, data_ack, err, grant_id, busy, winner_req, winner_data_req);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int t;
        req = 4'b0010;
        data_req[1*RW +: RW] = 8'h41;
        push(4'b0010, 8'h42, 1'b0);
        wait_grant(t);
        check_gid("single_gid", 2'd1);
        total++;
        if (winner_data_req !== 8'h41 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_wdat wdat=%h busy=%b required 41 1", winner_data_req, busy);
        end
        req = '0;
        step();
        step();
        total++;
        if (ack !== 4'b0010 || cyc - t != 2) begin
            bad++;
            $display("FAIL single_latency ack=%b after %0d edges required 0010 after 2", ack, cyc - t);
        end
        step();
        total++;
        if (ack !== 4'b0000) begin
            bad++;
            $display("FAIL single_pulse ack=%b required 0000", ack);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        int t;
        int tp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) data_req[i*RW +: RW] = 8'h10 + 8'(i);
        for (int i = 0; i < 5; i++) push(4'b0001 << (i % N), 8'h11 + 8'(i % N), 1'b0);
        req = 4'b1111;
        tp = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(t);
            check_gid("rr_order", 2'(i % N));
            if (i > 0) begin
                total++;
                if (t - tp != 4) begin
                    bad++;
                    $display("FAIL rr_spacing grant gap=%0d required 4", t - tp);
                end
            end
            tp = t;
            if (i == 4) req = '0;
            wait_low();
        end
        wait_idle();
    endtask

    task automatic test_skip_wrap();
        int t;
        data_req[0*RW +: RW] = 8'hA0;
        data_req[2*RW +: RW] = 8'hA2;
        push(4'b0100, 8'hA3, 1'b0);
        push(4'b0001, 8'hA1, 1'b0);
        req = 4'b0101;
        wait_grant(t);
        check_gid("skip_first", 2'd2);
        req = 4'b0001;
        wait_low();
        wait_grant(t);
        check_gid("wrap_second", 2'd0);
        req = '0;
        wait_idle();
    endtask

    task automatic test_timeout();
        int t;
        resp_auto = 1'b0;
        man_ack = 1'b0;
        data_req[3*RW +: RW] = 8'hC3;
        push(4'b1000, 8'h00, 1'b1);
        req = 4'b1000;
        wait_grant(t);
        check_gid("tmo_gid", 2'd3);
        req = '0;
        repeat (TO - 1) step();
        total++;
        if (ack !== '0) begin
            bad++;
            $display("FAIL tmo_early ack=%b required 0000", ack);
        end
        step();
        total++;
        if (ack !== 4'b1000 || err !== 1'b1 || data_ack !== 8'h00 || cyc - t != TO) begin
            bad++;
            $display("FAIL tmo_fire ack=%b err=%b dack=%h at %0d edges required 1000 1 00 at %0d",
                     ack, err, data_ack, cyc - t, TO);
        end
        step();
        man_ack = 1'b1;
        man_dat = 8'h55;
        step();
        man_ack = 1'b0;
        total++;
        if (busy !== 1'b0 || winner_req !== 1'b0 || ack !== '0) begin
            bad++;
            $display("FAIL tmo_late_ack busy=%b wreq=%b ack=%b required 0 0 0000", busy, winner_req, ack);
        end
        step();
    endtask

    task automatic test_ack_timeout_tie();
        int t;
        data_req[0*RW +: RW] = 8'h5A;
        push(4'b0001, 8'h77, 1'b0);
        req = 4'b0001;
        wait_grant(t);
        check_gid("tie_gid", 2'd0);
        req = '0;
        repeat (TO - 1) step();
        man_ack = 1'b1;
        man_dat = 8'h77;
        step();
        man_ack = 1'b0;
        total++;
        if (ack !== 4'b0001 || err !== 1'b0 || data_ack !== 8'h77) begin
            bad++;
            $display("FAIL tie ack=%b err=%b dack=%h required 0001 0 77", ack, err, data_ack);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_busy();
        int t;
        data_req[2*RW +: RW] = 8'h99;
        req = 4'b0100;
        wait_grant(t);
        check_gid("rstb_gid", 2'd2);
        req = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        total++;
        if (winner_req !== 1'b0 || ack !== '0 || busy !== 1'b0 || grant_id !== 2'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rstb_clear wreq=%b ack=%b busy=%b gid=%0d err=%b required all 0",
                     winner_req, ack, busy, grant_id, err);
        end
        rst = 1'b0;
        resp_auto = 1'b1;
        for (int i = 0; i < N; i++) data_req[i*RW +: RW] = 8'h20 + 8'(i);
        push(4'b0001, 8'h21, 1'b0);
        req = 4'b1111;
        wait_grant(t);
        check_gid("rstb_restart", 2'd0);
        req = '0;
        wait_idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        data_req = '0;
        resp_auto = 1'b1;
        man_ack = 1'b0;
        man_dat = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_timeout();
        test_ack_timeout_tie();
        test_reset_mid_busy();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover pending=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
